axis_rr_arbiter: RTL

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

---
 rtl/axis_rr_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: merges NUM_PORTS AXI-Stream slaves into one master stream.
// Grant is chosen round-robin, starting one past the last served port. The
// merged stream comes out of a single output register.
// Configuration macro AXIS_RR_ARBITER_PKT_LOCK_EN:
//   defined   -> the grant is held until the granted port sends a tlast beat
//   undefined -> the grant is released after every beat (per-beat round-robin)
module axis_rr_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PORTS  = 4
) (
    input  logic                            clk_i,
    input  logic                            arstn_i,
    input  logic [NUM_PORTS-1:0]            s_tvalid_i,
    output logic [NUM_PORTS-1:0]            s_tready_o,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata_i,
    input  logic [NUM_PORTS-1:0]            s_tlast_i,
    output logic                            m_tvalid_o,
    input  logic                            m_tready_i,
    output logic [DATA_WIDTH-1:0]           m_tdata_o,
    output logic                            m_tlast_o,
    output logic [NUM_PORTS-1:0]            grant_o,
    output logic                            busy_o
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                 state_reg;
    logic [NUM_PORTS-1:0]   grant_reg;
    logic [IDX_W-1:0]       grant_idx_reg;
    logic [IDX_W-1:0]       last_grant_reg;
    logic                   m_tvalid_reg;
    logic [DATA_WIDTH-1:0]  m_tdata_reg;
    logic                   m_tlast_reg;

    logic [DATA_WIDTH-1:0]  port_data [NUM_PORTS];
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       cand_idx;
    logic                   out_free;
    logic                   beat;
    logic                   release_grant;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   sel_last;

    // Unpack the flat tdata bus into one word per port.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign port_data[gi] = s_tdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin search: first valid port after last_grant, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand_idx = IDX_W'((int'(last_grant_reg) + k) % NUM_PORTS);
            if (!pick_found && s_tvalid_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Handshake decode for the granted port; the output register accepts a
    // new beat when it is empty or being drained this cycle.
    always_comb begin
        out_free   = ~m_tvalid_reg | m_tready_i;
        s_tready_o = (state_reg == LOCKED) ? (grant_reg & {NUM_PORTS{out_free}}) : '0;
        beat       = |(s_tvalid_i & s_tready_o);
        sel_data   = port_data[grant_idx_reg];
        sel_last   = s_tlast_i[grant_idx_reg];
`ifdef AXIS_RR_ARBITER_PKT_LOCK_EN
        release_grant = beat & sel_last;
`else
        release_grant = beat;
`endif
    end

    // Arbitration FSM together with the registered output stage.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            grant_idx_reg  <= '0;
            last_grant_reg <= IDX_W'(NUM_PORTS - 1);
            m_tvalid_reg   <= 1'b0;
            m_tdata_reg    <= '0;
            m_tlast_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        state_reg     <= LOCKED;
                        grant_idx_reg <= pick_idx;
                        grant_reg     <= NUM_PORTS'(1) << pick_idx;
                    end
                end
                LOCKED: begin
                    if (release_grant) begin
                        state_reg      <= IDLE;
                        grant_reg      <= '0;
                        last_grant_reg <= grant_idx_reg;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant_reg <= '0;
                end
            endcase

            // Load on a beat; otherwise drop valid once the sink takes the word.
            if (beat) begin
                m_tvalid_reg <= 1'b1;
                m_tdata_reg  <= sel_data;
                m_tlast_reg  <= sel_last;
            end else if (m_tready_i) begin
                m_tvalid_reg <= 1'b0;
            end
        end
    end

    assign m_tvalid_o = m_tvalid_reg;
    assign m_tdata_o  = m_tdata_reg;
    assign m_tlast_o  = m_tlast_reg;
    assign grant_o    = (state_reg == LOCKED) ? grant_reg : '0;
    assign busy_o     = (state_reg == LOCKED);

endmodule
